// File: rtl/frog_input_cond.sv
`default_nettype none
// ============================================================================
//  Module   : frog_input_cond
//  Purpose  : Input conditioning for the frog game player controls.
//             Synchronises and debounces the four board switches, then turns
//             presses into single-cycle, mutually exclusive move strobes
//             (priority up > down > left > right).
//  Ports    : CLK        in   system clock
//             RST        in   synchronous, active-high reset
//             SW1..SW4   in   raw async buttons: up, down, left, right
//             move_up    out  one-cycle strobe
//             move_down  out  one-cycle strobe
//             move_left  out  one-cycle strobe
//             move_right out  one-cycle strobe
//             btn_level  out  debounced levels {SW4,SW3,SW2,SW1}
//  Options  : FROG_AUTOREPEAT_EN - when defined, a held button auto-repeats
//             after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module frog_input_cond #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 7500000,
  parameter int REPEAT_PERIOD   = 3750000,
  parameter int CNT_W           = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic [3:0] btn_level
);

  localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations whose counts cannot be represented in CNT_W bits.
  if ((DEBOUNCE_CYCLES < 1) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) ||
      (DEBOUNCE_CYCLES > (1 << CNT_W)) || (REPEAT_DELAY > (1 << CNT_W)) ||
      (REPEAT_PERIOD > (1 << CNT_W))) begin : g_param_err
    $error("frog_input_cond: counter parameters out of range for CNT_W");
  end

`ifdef FROG_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] C_RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] C_RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;
`endif

  logic [3:0] sync_a;
  logic [3:0] sync_s;
  logic [3:0] level_d;
  logic [3:0] rise;
  logic [3:0] req;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_a  <= '0;
      sync_s  <= '0;
      level_d <= '0;
    end else begin
      sync_a  <= {SW4, SW3, SW2, SW1};
      sync_s  <= sync_a;
      level_d <= btn_level;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    // The count only survives while the synced input keeps disagreeing with
    // the accepted level, so any shorter glitch restarts it.
    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync_s[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == C_DB_LAST) begin
        lvl <= sync_s[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign btn_level[i] = lvl;
    assign rise[i]      = lvl & ~level_d[i];

`ifdef FROG_AUTOREPEAT_EN
    rpt_state_t       state;
    rpt_state_t       state_nxt;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_nxt;
    logic             rep;

    always_ff @(posedge CLK) begin
      if (RST) begin
        state <= RPT_IDLE;
        rcnt  <= '0;
      end else begin
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
      end
    end

    // rcnt keeps running whether or not the repeat wins arbitration.
    // A release takes priority, suppressing a repeat due in the same cycle.
    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      rep       = 1'b0;
      case (state)
        RPT_IDLE: begin
          rcnt_nxt = '0;
          if (rise[i]) state_nxt = RPT_DELAY;
        end
        RPT_DELAY: begin
          if (!lvl) begin
            state_nxt = RPT_IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == C_RD_LAST) begin
            rep       = 1'b1;
            state_nxt = RPT_REPEAT;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + CNT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (!lvl) begin
            state_nxt = RPT_IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == C_RP_LAST) begin
            rep      = 1'b1;
            rcnt_nxt = '0;
          end else begin
            rcnt_nxt = rcnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = RPT_IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end

    assign req[i] = rise[i] | rep;
`else
    assign req[i] = rise[i];
`endif
  end

  // Fixed-priority arbitration; losing requests are simply dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      move_up    <= 1'b0;
      move_down  <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else begin
      move_up    <= req[0];
      move_down  <= req[1] & ~req[0];
      move_left  <= req[2] & ~(|req[1:0]);
      move_right <= req[3] & ~(|req[2:0]);
    end
  end

endmodule
`default_nettype wire
